// File: rtl/bcd_arb_pkg.sv
// -----------------------------------------------------------------------------
// bcd_arb_pkg
// Shared definitions for the BCD converter arbiter:
//   BIN_W    - width of the binary operand driven to the converter (E..A)
//   BCD_W    - width of the two-digit BCD result returned (Y8..Y1)
//   state_e  - controller states IDLE / DRIVE / RESP
//   bcd_digit_err - flags a BCD byte whose tens or units nibble is above 9
// -----------------------------------------------------------------------------
package bcd_arb_pkg;

    localparam int BIN_W = 5;
    localparam int BCD_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        RESP  = 2'd2
    } state_e;

    // A legal BCD digit is 0..9; anything above that means the converter
    // produced a value that cannot be a decimal digit.
    function automatic logic bcd_digit_err(input logic [BCD_W-1:0] bcd);
        return (bcd[7:4] > 4'd9) || (bcd[3:0] > 4'd9);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin selector. The search for a pending request starts
// at index ptr_i and wraps around modulo N_REQ; the first pending index found
// wins.
// Ports:
//   req_i    [N_REQ-1:0] pending requests
//   ptr_i    [IW-1:0]    index where the search starts
//   onehot_o [N_REQ-1:0] one-hot winner (all zero when nothing is pending)
//   idx_o    [IW-1:0]    binary index of the winner
//   valid_o              at least one request is pending
// -----------------------------------------------------------------------------
module rr_arbiter
    import bcd_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IW-1:0]    ptr_i,
    output logic [N_REQ-1:0] onehot_o,
    output logic [IW-1:0]    idx_o,
    output logic             valid_o
);

    logic [IW-1:0] cand;

    // Walk the requesters in priority order ptr, ptr+1, ... and keep the first hit.
    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        valid_o  = 1'b0;
        cand     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = IW'((int'(ptr_i) + i) % N_REQ);
            if (!valid_o && req_i[cand]) begin
                valid_o        = 1'b1;
                onehot_o[cand] = 1'b1;
                idx_o          = cand;
            end else begin
                valid_o = valid_o;
            end
        end
    end

endmodule

// File: rtl/bcd_conv_arbiter.sv
// -----------------------------------------------------------------------------
// bcd_conv_arbiter
// Shares one external binary-to-BCD converter among N_REQ requesters.
// A round-robin winner's 5-bit operand is latched and driven to the converter
// with its active-low enable asserted for SETTLE_CYC cycles; the converter
// result is then captured and offered on a valid/ready response port.
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   req / req_data       per-requester request and 5-bit operand (slice i)
//   gnt                  registered one-cycle one-hot grant
//   conv_G / conv_bin    converter enable (active-low) and operand
//   conv_bcd             converter result
//   rsp_valid/rsp_ready  response handshake
//   rsp_id/rsp_bcd/rsp_err  served index, captured BCD, invalid-digit flag
//   busy                 controller is not IDLE
// -----------------------------------------------------------------------------
module bcd_conv_arbiter
    import bcd_arb_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int SETTLE_CYC = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    input  logic [BIN_W*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]         gnt,
    output logic                     conv_G,
    output logic [BIN_W-1:0]         conv_bin,
    input  logic [BCD_W-1:0]         conv_bcd,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(N_REQ)-1:0] rsp_id,
    output logic [BCD_W-1:0]         rsp_bcd,
    output logic                     rsp_err,
    output logic                     busy
);

    localparam int         IW       = $clog2(N_REQ);
    localparam logic [2:0] LAST_CNT = 3'(SETTLE_CYC - 1);

    state_e            state_q;
    logic [IW-1:0]     ptr_q;
    logic [IW-1:0]     ptr_d;
    logic [2:0]        cnt_q;
    logic [N_REQ-1:0]  gnt_q;
    logic              conv_g_q;
    logic [BIN_W-1:0]  conv_bin_q;
    logic              rsp_valid_q;
    logic [IW-1:0]     rsp_id_q;
    logic [BCD_W-1:0]  rsp_bcd_q;
    logic              rsp_err_q;
    logic              busy_q;

    logic [N_REQ-1:0]  win_onehot;
    logic [IW-1:0]     win_idx;
    logic              any_req;
    logic [BIN_W-1:0]  win_data;
    logic              launch;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_rr (
        .req_i    (req),
        .ptr_i    (ptr_q),
        .onehot_o (win_onehot),
        .idx_o    (win_idx),
        .valid_o  (any_req)
    );

    // Pick the winner's operand slice using the one-hot vector (constant slices only).
    always_comb begin
        win_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_onehot[i]) begin
                win_data = req_data[i*BIN_W +: BIN_W];
            end else begin
                win_data = win_data;
            end
        end
    end

    // Next search start is one past the winner, wrapping at N_REQ.
    assign ptr_d = (win_idx == IW'(N_REQ - 1)) ? '0 : win_idx + IW'(1);

    // A new conversion starts from IDLE, or straight out of RESP on the
    // consuming edge, so back-to-back requesters never pass through IDLE.
    assign launch = any_req &&
                    ((state_q == IDLE) || ((state_q == RESP) && rsp_ready));

    // Controller FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            cnt_q       <= 3'd0;
            gnt_q       <= '0;
            conv_g_q    <= 1'b1;
            conv_bin_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_bcd_q   <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            gnt_q <= '0;
            if (launch) begin
                // Operand and index are latched here; later req/req_data
                // changes cannot reach the in-flight conversion.
                state_q     <= DRIVE;
                busy_q      <= 1'b1;
                gnt_q       <= win_onehot;
                rsp_id_q    <= win_idx;
                conv_bin_q  <= win_data;
                conv_g_q    <= 1'b0;
                cnt_q       <= 3'd0;
                ptr_q       <= ptr_d;
                rsp_valid_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                    DRIVE: begin
                        if (cnt_q == LAST_CNT) begin
                            rsp_bcd_q   <= conv_bcd;
                            rsp_err_q   <= bcd_digit_err(conv_bcd);
                            rsp_valid_q <= 1'b1;
                            conv_g_q    <= 1'b1;
                            state_q     <= RESP;
                        end else begin
                            cnt_q <= cnt_q + 3'd1;
                        end
                    end
                    RESP: begin
                        if (rsp_ready) begin
                            rsp_valid_q <= 1'b0;
                            state_q     <= IDLE;
                            busy_q      <= 1'b0;
                        end else begin
                            state_q <= RESP;
                        end
                    end
                    default: begin
                        state_q     <= IDLE;
                        busy_q      <= 1'b0;
                        conv_g_q    <= 1'b1;
                        rsp_valid_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign gnt       = gnt_q;
    assign conv_G    = conv_g_q;
    assign conv_bin  = conv_bin_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_bcd   = rsp_bcd_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bcd_conv_arbiter
// Scoreboard bench: directed stimulus pushes expected grants and responses into
// queues; negedge monitors pop and compare whenever gnt is non-zero or a
// response handshake is presented. A second instance with SETTLE_CYC=3 covers
// reset during DRIVE, longer latency and late data changes.
// -----------------------------------------------------------------------------
module tb_bcd_conv_arbiter;

    typedef struct {
        logic [1:0] id;
        logic [7:0] bcd;
        logic       err;
    } rsp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance, SETTLE_CYC = 1
    logic        reset;
    logic [3:0]  req;
    logic [19:0] req_data;
    logic [3:0]  gnt;
    logic        conv_G;
    logic [4:0]  conv_bin;
    logic [7:0]  conv_bcd;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_bcd;
    logic        rsp_err;
    logic        busy;

    // second instance, SETTLE_CYC = 3
    logic        reset3;
    logic [3:0]  req3;
    logic [19:0] req3_data;
    logic [3:0]  gnt3;
    logic        conv_G3;
    logic [4:0]  conv_bin3;
    logic [7:0]  conv_bcd3;
    logic        rsp_valid3;
    logic        rsp_ready3;
    logic [1:0]  rsp_id3;
    logic [7:0]  rsp_bcd3;
    logic        rsp_err3;
    logic        busy3;

    logic        force_en;
    logic [7:0]  force_val;

    int   checks   = 0;
    int   errors   = 0;
    int   rv3_seen = 0;
    rsp_t rsp_q[$];
    int   gnt_q[$];
    rsp_t exp_r;
    int   exp_g;

    bcd_conv_arbiter #(.N_REQ(4), .SETTLE_CYC(1)) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data), .gnt(gnt),
        .conv_G(conv_G), .conv_bin(conv_bin), .conv_bcd(conv_bcd),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_bcd(rsp_bcd), .rsp_err(rsp_err), .busy(busy)
    );

    bcd_conv_arbiter #(.N_REQ(4), .SETTLE_CYC(3)) dut3 (
        .clk(clk), .reset(reset3), .req(req3), .req_data(req3_data), .gnt(gnt3),
        .conv_G(conv_G3), .conv_bin(conv_bin3), .conv_bcd(conv_bcd3),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_id(rsp_id3),
        .rsp_bcd(rsp_bcd3), .rsp_err(rsp_err3), .busy(busy3)
    );

    function automatic logic [7:0] bin2bcd(input logic [4:0] b);
        logic [4:0] t;
        logic [4:0] o;
        t = b / 5'd10;
        o = b % 5'd10;
        return {t[3:0], o[3:0]};
    endfunction

    // Behavioral converter: output is garbage (FF) unless enabled.
    always_comb begin
        if (conv_G)        conv_bcd = 8'hFF;
        else if (force_en) conv_bcd = force_val;
        else               conv_bcd = bin2bcd(conv_bin);
    end

    always_comb conv_bcd3 = conv_G3 ? 8'hFF : bin2bcd(conv_bin3);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_grant(input int idx);
        gnt_q.push_back(idx);
    endtask

    task automatic exp_rsp(input logic [1:0] id, input logic [7:0] bcd, input logic err);
        rsp_t r;
        r.id  = id;
        r.bcd = bcd;
        r.err = err;
        rsp_q.push_back(r);
    endtask

    // Monitor: grants and response handshakes of the main instance.
    always @(negedge clk) begin
        if (!reset && gnt != 4'b0000) begin
            if (gnt_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL gnt_unexpected: got gnt=%b, required no grant", gnt);
            end else begin
                exp_g = gnt_q.pop_front();
                check("gnt_onehot", {28'd0, gnt}, {28'd0, 4'(1 << exp_g)});
            end
        end
        if (!reset && rsp_valid && rsp_ready) begin
            if (rsp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got id=%0d bcd=%h, required no response", rsp_id, rsp_bcd);
            end else begin
                exp_r = rsp_q.pop_front();
                check("rsp_id",  {30'd0, rsp_id},  {30'd0, exp_r.id});
                check("rsp_bcd", {24'd0, rsp_bcd}, {24'd0, exp_r.bcd});
                check("rsp_err", {31'd0, rsp_err}, {31'd0, exp_r.err});
            end
        end
    end

    // Monitor: any response ever presented by the SETTLE_CYC=3 instance.
    always @(negedge clk) begin
        if (rsp_valid3 === 1'b1) rv3_seen++;
    end

    task automatic wait_gnt(input bit sel, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (sel) seen = (gnt3 != 4'b0000);
            else     seen = (gnt != 4'b0000);
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s: got no gnt within 20 cycles, required a grant", name);
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 60 && (rsp_q.size() != 0 || gnt_q.size() != 0); i++) begin
            tick();
        end
        check(name, rsp_q.size() + gnt_q.size(), 0);
    endtask

    task automatic wait_valid3(output int n);
        bit seen;
        seen = 1'b0;
        n = 0;
        for (int i = 0; i < 12 && !seen; i++) begin
            tick();
            n++;
            seen = rsp_valid3;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int busy_low;
        int hold_bad;

        reset = 1'b1;  req  = 4'b0000; req_data  = 20'd0; rsp_ready  = 1'b1;
        reset3 = 1'b1; req3 = 4'b0000; req3_data = 20'd0; rsp_ready3 = 1'b1;
        force_en = 1'b0; force_val = 8'h00;
        repeat (3) tick();

        // reset state
        check("rst_gnt",       {28'd0, gnt},      32'd0);
        check("rst_conv_G",    {31'd0, conv_G},   32'd1);
        check("rst_conv_bin",  {27'd0, conv_bin}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_id",    {30'd0, rsp_id},   32'd0);
        check("rst_rsp_bcd",   {24'd0, rsp_bcd},  32'd0);
        check("rst_rsp_err",   {31'd0, rsp_err},  32'd0);
        check("rst_busy",      {31'd0, busy},     32'd0);
        reset = 1'b0;
        reset3 = 1'b0;

        // single request: requester 2, operand 23
        req_data[14:10] = 5'd23;
        exp_grant(2);
        exp_rsp(2'd2, 8'h23, 1'b0);
        req = 4'b0100;
        wait_gnt(1'b0, "t1_gnt");
        req = 4'b0000;
        check("t1_conv_G_low", {31'd0, conv_G}, 32'd0);
        check("t1_conv_bin",   {27'd0, conv_bin}, 32'd23);
        check("t1_busy",       {31'd0, busy}, 32'd1);
        tick();
        check("t1_conv_G_high", {31'd0, conv_G}, 32'd1);
        check("t1_valid",       {31'd0, rsp_valid}, 32'd1);
        drain("t1_drain");

        // all requesters held, from reset pointer: order 0,1,2,3,0
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        req_data = {5'd30, 5'd19, 5'd12, 5'd5};
        exp_grant(0); exp_grant(1); exp_grant(2); exp_grant(3); exp_grant(0);
        exp_rsp(2'd0, 8'h05, 1'b0);
        exp_rsp(2'd1, 8'h12, 1'b0);
        exp_rsp(2'd2, 8'h19, 1'b0);
        exp_rsp(2'd3, 8'h30, 1'b0);
        exp_rsp(2'd0, 8'h05, 1'b0);
        req = 4'b1111;
        n = 0;
        busy_low = 0;
        for (int i = 0; i < 40 && n < 5; i++) begin
            tick();
            if (n >= 1 && !busy) busy_low++;
            if (gnt != 4'b0000) n++;
        end
        req = 4'b0000;
        check("t2_grant_count", n, 5);
        check("t2_no_idle_gap", busy_low, 0);
        drain("t2_drain");

        // backpressure: requester 1 operand 31 held, requester 3 waits
        rsp_ready = 1'b0;
        req_data[9:5]   = 5'd31;
        req_data[19:15] = 5'd7;
        exp_grant(1); exp_grant(3);
        exp_rsp(2'd1, 8'h31, 1'b0);
        exp_rsp(2'd3, 8'h07, 1'b0);
        req = 4'b1010;
        wait_gnt(1'b0, "t3_gnt");
        req = 4'b1000;
        tick();
        check("t3_valid", {31'd0, rsp_valid}, 32'd1);
        hold_bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (!rsp_valid || rsp_bcd != 8'h31 || rsp_id != 2'd1 || gnt != 4'b0000) hold_bad++;
        end
        check("t3_hold_stable", hold_bad, 0);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        tick();
        check("t3_regrant_same_edge", {28'd0, gnt}, 32'h8);
        check("t3_valid_cleared",     {31'd0, rsp_valid}, 32'd0);
        req = 4'b0000;
        drain("t3_drain");

        // error flag: low nibble and high nibble out of range
        force_en = 1'b1;
        force_val = 8'h4B;
        req_data[4:0] = 5'd13;
        exp_grant(0);
        exp_rsp(2'd0, 8'h4B, 1'b1);
        req = 4'b0001;
        wait_gnt(1'b0, "t4a_gnt");
        req = 4'b0000;
        drain("t4a_drain");
        force_val = 8'hA3;
        req_data[9:5] = 5'd2;
        exp_grant(1);
        exp_rsp(2'd1, 8'hA3, 1'b1);
        req = 4'b0010;
        wait_gnt(1'b0, "t4b_gnt");
        req = 4'b0000;
        drain("t4b_drain");
        force_en = 1'b0;

        // data change after grant on main instance
        req_data[9:5] = 5'd9;
        exp_grant(1);
        exp_rsp(2'd1, 8'h09, 1'b0);
        req = 4'b0010;
        wait_gnt(1'b0, "t5_gnt");
        req = 4'b0000;
        req_data[9:5] = 5'd17;
        drain("t5_drain");

        // SETTLE_CYC=3: reset during DRIVE discards the conversion
        req3_data[4:0] = 5'd20;
        req3 = 4'b0001;
        wait_gnt(1'b1, "t6_gnt");
        req3 = 4'b0000;
        tick();
        check("t6_in_drive", {31'd0, conv_G3}, 32'd0);
        reset3 = 1'b1;
        tick();
        check("t6_rst_conv_G", {31'd0, conv_G3},    32'd1);
        check("t6_rst_valid",  {31'd0, rsp_valid3}, 32'd0);
        check("t6_rst_busy",   {31'd0, busy3},      32'd0);
        check("t6_rst_gnt",    {28'd0, gnt3},       32'd0);
        reset3 = 1'b0;
        repeat (8) tick();
        check("t6_no_response", rv3_seen, 0);

        // pointer restarted at 0, and latency is SETTLE_CYC cycles
        req3_data = {5'd4, 5'd3, 5'd2, 5'd20};
        req3 = 4'b1111;
        wait_gnt(1'b1, "t7_gnt");
        check("t7_ptr_zero", {28'd0, gnt3}, 32'h1);
        req3 = 4'b0000;
        wait_valid3(n);
        check("t7_latency", n, 3);
        check("t7_bcd",     {24'd0, rsp_bcd3}, 32'h20);
        check("t7_id",      {30'd0, rsp_id3},  32'd0);
        check("t7_err",     {31'd0, rsp_err3}, 32'd0);
        tick();

        // data change one cycle after grant while the conversion is in flight
        req3_data[9:5] = 5'd9;
        req3 = 4'b0010;
        wait_gnt(1'b1, "t8_gnt");
        check("t8_gnt", {28'd0, gnt3}, 32'h2);
        req3 = 4'b0000;
        tick();
        req3_data[9:5] = 5'd17;
        check("t8_conv_bin", {27'd0, conv_bin3}, 32'd9);
        wait_valid3(n);
        check("t8_latency", n, 2);
        check("t8_bcd",     {24'd0, rsp_bcd3}, 32'h09);
        check("t8_id",      {30'd0, rsp_id3},  32'd1);
        tick();

        check("sb_rsp_empty", rsp_q.size(), 0);
        check("sb_gnt_empty", gnt_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bcd_conv_arbiter.md
BCD_CONV_ARBITER -- requirements
Module: bcd_conv_arbiter

Interface
REQ-001 Parameter N_REQ, 4, number of requesters (2..8).
REQ-002 Parameter SETTLE_CYC, 1, cycles the converter enable is held low before capture (1..7).
REQ-003 Port clk  in  1  single clock; all state changes on rising edge.
REQ-004 Port reset  in  1  synchronous reset, active-high.
REQ-005 Port req  in  N_REQ  per-requester conversion request; held high with stable data until granted.
REQ-006 Port req_data  in  5*N_REQ  5-bit binary operand per requester; slice i = bits [5i+4:5i].
REQ-007 Port gnt  out  N_REQ  registered one-hot grant pulse, one cycle.
REQ-008 Port conv_G  out  1  converter enable, active-low.
REQ-009 Port conv_bin  out  5  operand to converter; bit 4 = E, bit 0 = A.
REQ-010 Port conv_bcd  in  8  converter result; bit 7 = Y8, bit 0 = Y1.
REQ-011 Port rsp_valid  out  1  response valid.
REQ-012 Port rsp_ready  in  1  response consumer ready.
REQ-013 Port rsp_id  out  clog2(N_REQ)  index of the served requester.
REQ-014 Port rsp_bcd  out  8  captured BCD result.
REQ-015 Port rsp_err  out  1  high if either captured nibble exceeds 9.
REQ-016 Port busy  out  1  high in any state other than IDLE.

Function
REQ-017 FSM states SHALL be IDLE, DRIVE and RESP.
REQ-018 IDLE: on an edge where any req bit is high, the block SHALL select one winner, latch its req_data slice and index, assert gnt for that winner for the next cycle only, and enter DRIVE.
REQ-019 Arbitration SHALL be round-robin: search starts at (last winner + 1) mod N_REQ; after reset the search starts at index 0.
REQ-020 DRIVE: conv_G SHALL be 0 and conv_bin SHALL equal the latched operand for exactly SETTLE_CYC cycles.
REQ-021 On the last DRIVE edge, conv_bcd SHALL be captured into rsp_bcd, rsp_err SHALL be computed from the captured nibbles, rsp_valid SHALL be set, and the state SHALL become RESP.
REQ-022 Latency: with req sampled at edge k, rsp_valid SHALL be high after edge k+SETTLE_CYC.
REQ-023 RESP: rsp_valid, rsp_id, rsp_bcd and rsp_err SHALL hold stable until an edge where rsp_ready is high.
REQ-024 On that edge, if any req is high, the block SHALL arbitrate and enter DRIVE directly with rsp_valid cleared; otherwise it SHALL enter IDLE.
REQ-025 Outside DRIVE, conv_G SHALL be 1 and conv_bin SHALL hold its last value.
REQ-026 A requester that keeps req high after its grant SHALL be served again only after every other pending requester.
REQ-027 Changes to req or req_data after the granting edge SHALL NOT affect the in-flight conversion.
REQ-028 rsp_ready while rsp_valid is low SHALL be ignored.

Reset
REQ-029 Reset SHALL force IDLE, gnt=0, conv_G=1, conv_bin=0, rsp_valid=0, rsp_id=0, rsp_bcd=0, rsp_err=0, busy=0, and the round-robin pointer to 0.
REQ-030 Reset asserted in DRIVE or RESP SHALL discard the in-flight conversion with no response.

Structure
REQ-031 Package bcd_arb_pkg SHALL hold the state enum and the constants BIN_W=5 and BCD_W=8.
REQ-032 Round-robin selection SHALL live in sub-module rr_arbiter: inputs are req and the pointer; outputs are a one-hot winner and its index; combinational.
REQ-033 The converter SHALL be external to this block; the bench SHALL use a behavioral model that returns the BCD of the operand.

Verification
REQ-034 Single request: req=0100, data[2]=23 -> gnt=0100 for one cycle, conv_G low for 1 cycle, then rsp_bcd=8'h23, rsp_id=2, rsp_err=0.
REQ-035 All requesters: req=1111 held, rsp_ready=1 -> grant order 0,1,2,3,0, with no IDLE cycle between responses.
REQ-036 Backpressure: rsp_ready=0 for 5 cycles with operand 31 -> rsp_bcd=8'h31 held stable and no new gnt; release -> next grant on the same edge.
REQ-037 Error flag: the model forces conv_bcd=8'h4B -> rsp_err=1 and rsp_bcd=8'h4B.
REQ-038 Reset mid-DRIVE with SETTLE_CYC=3 -> the next cycle shows conv_G=1, rsp_valid=0 and pointer 0; no response is ever issued for that request.
REQ-039 Data change after grant: data[1] changes from 9 to 17 one cycle after gnt -> rsp_bcd=8'h09.
